// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Memory controller shared by the MEM stage and instruction fetch. It
// serialises 1/2/4-byte loads and stores, and 4-byte fetches, onto one
// byte-wide synchronous RAM port. Read data is assembled little-endian and
// zero-extended.
//
// Ports
//   clk, rst                        system clock, async active-high reset
//   mem_needed/addr/width/
//   read_write/sdata                MEM request (MEM wins over IF when both ask)
//   mem_rdy, mem_busy, mem_ldata    MEM completion pulse, busy flag, load result
//   if_needed/addr/flush            fetch request and branch flush
//   if_rdy, if_busy, if_inst        fetch completion pulse, busy flag, word
//   ram_a, ram_wr, ram_dout, ram_din  byte RAM port (read data one cycle late)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no transaction; requests sampled at each edge
// RD    | reading w bytes; byte cnt-1 captured from ram_din each cycle
// WR    | writing byte cnt of the store data each cycle
// -----------------------------------------------------------------------------
module mem_ctrl #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                mem_needed,
    input  logic [ADDR_LEN-1:0] mem_addr,
    input  logic [2:0]          mem_width,
    input  logic                mem_read_write,
    input  logic [DATA_LEN-1:0] mem_sdata,
    output logic                mem_rdy,
    output logic                mem_busy,
    output logic [DATA_LEN-1:0] mem_ldata,

    input  logic                if_needed,
    input  logic [ADDR_LEN-1:0] if_addr,
    input  logic                if_flush,
    output logic                if_rdy,
    output logic                if_busy,
    output logic [DATA_LEN-1:0] if_inst,

    output logic [ADDR_LEN-1:0] ram_a,
    output logic                ram_wr,
    output logic [7:0]          ram_dout,
    input  logic [7:0]          ram_din
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic                  owner_if;
    logic [ADDR_LEN-1:0]   addr;
    logic [2:0]            w;
    logic [DATA_LEN-1:0]   sdata;
    logic [2:0]            cnt;
    logic [DATA_LEN-1:0]   asm_buf;

    logic                  accept_mem;
    logic                  accept_if;
    logic                  done_rd;
    logic                  done_wr;
    logic                  flush_abort;
    logic [2:0]            mem_w_dec;
    logic [1:0]            cap_idx;
    logic [DATA_LEN-1:0]   asm_word;
    logic [ADDR_LEN-1:0]   byte_addr;

    // Anything other than 1 or 2 is treated as a full word.
    always_comb begin
        mem_w_dec = 3'd4;
        case (mem_width)
            3'd1:    mem_w_dec = 3'd1;
            3'd2:    mem_w_dec = 3'd2;
            default: mem_w_dec = 3'd4;
        endcase
    end

    // Address wraps naturally through the fixed-width add.
    assign byte_addr = addr + {{(ADDR_LEN-3){1'b0}}, cnt};

    // RAM data arrives one cycle after its address, so the byte landing in
    // cycle cnt belongs to offset cnt-1.
    assign cap_idx = cnt[1:0] - 2'd1;

    always_comb begin
        asm_word = asm_buf;
        if (cnt != 3'd0) begin
            asm_word[{cap_idx, 3'b000} +: 8] = ram_din;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept_mem  = 1'b0;
        accept_if   = 1'b0;
        done_rd     = 1'b0;
        done_wr     = 1'b0;
        flush_abort = 1'b0;
        case (state)
            IDLE: begin
                if (mem_needed) begin
                    accept_mem = 1'b1;
                    state_nxt  = mem_read_write ? RD : WR;
                end else if (if_needed && !if_flush) begin
                    accept_if = 1'b1;
                    state_nxt = RD;
                end
            end
            RD: begin
                // A flush beats completion: a fetch finishing on the same
                // edge is still dropped.
                if (owner_if && if_flush) begin
                    flush_abort = 1'b1;
                    state_nxt   = IDLE;
                end else if (cnt == w) begin
                    done_rd   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WR: begin
                if (cnt == w - 3'd1) begin
                    done_wr   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // RAM port is decoded purely from state so reset silences it immediately.
    always_comb begin
        ram_a    = '0;
        ram_wr   = 1'b0;
        ram_dout = 8'h00;
        case (state)
            RD: begin
                if (cnt < w) begin
                    ram_a = byte_addr;
                end
            end
            WR: begin
                ram_wr   = 1'b1;
                ram_a    = byte_addr;
                ram_dout = sdata[{cnt[1:0], 3'b000} +: 8];
            end
            default: ;
        endcase
    end

    assign mem_busy = (state != IDLE);
    assign if_busy  = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner_if  <= 1'b0;
            addr      <= '0;
            w         <= 3'd0;
            sdata     <= '0;
            cnt       <= 3'd0;
            asm_buf   <= '0;
            mem_rdy   <= 1'b0;
            if_rdy    <= 1'b0;
            mem_ldata <= '0;
            if_inst   <= '0;
        end else begin
            state   <= state_nxt;
            mem_rdy <= 1'b0;
            if_rdy  <= 1'b0;
            if (accept_mem) begin
                owner_if <= 1'b0;
                addr     <= mem_addr;
                w        <= mem_w_dec;
                sdata    <= mem_sdata;
                cnt      <= 3'd0;
                asm_buf  <= '0;
            end else if (accept_if) begin
                owner_if <= 1'b1;
                addr     <= if_addr;
                w        <= 3'd4;
                cnt      <= 3'd0;
                asm_buf  <= '0;
            end else if (state == RD && !flush_abort) begin
                asm_buf <= asm_word;
                cnt     <= cnt + 3'd1;
                if (done_rd) begin
                    if (owner_if) begin
                        if_inst <= asm_word;
                        if_rdy  <= 1'b1;
                    end else begin
                        mem_ldata <= asm_word;
                        mem_rdy   <= 1'b1;
                    end
                end
            end else if (state == WR) begin
                cnt <= cnt + 3'd1;
                if (done_wr) begin
                    mem_rdy <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_needed = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [2:0]  mem_width = 3'd0;
    logic        mem_read_write = 1'b0;
    logic [31:0] mem_sdata = '0;
    logic        mem_rdy, mem_busy;
    logic [31:0] mem_ldata;
    logic        if_needed = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_flush = 1'b0;
    logic        if_rdy, if_busy;
    logic [31:0] if_inst;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = 8'h00;

    int tests = 0;
    int fails = 0;

    logic [7:0]  ram [logic [31:0]];
    logic        pre_we = 1'b0;
    logic [31:0] pre_a = '0;
    logic [7:0]  pre_d = '0;

    mem_ctrl #(.ADDR_LEN(32), .DATA_LEN(32)) dut (
        .clk(clk), .rst(rst),
        .mem_needed(mem_needed), .mem_addr(mem_addr), .mem_width(mem_width),
        .mem_read_write(mem_read_write), .mem_sdata(mem_sdata),
        .mem_rdy(mem_rdy), .mem_busy(mem_busy), .mem_ldata(mem_ldata),
        .if_needed(if_needed), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdy(if_rdy), .if_busy(if_busy), .if_inst(if_inst),
        .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM: read data valid the cycle after the address.
    always @(posedge clk) begin
        if (pre_we) ram[pre_a] = pre_d;
        if (ram_wr) ram[ram_a] = ram_dout;
        ram_din <= ram.exists(ram_a) ? ram[ram_a] : 8'h00;
    end

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    // Advance to the middle (falling edge) of the next cycle.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [31:0] a, input logic [7:0] d);
        pre_a = a; pre_d = d; pre_we = 1'b1;
        step();
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++; if (mem_busy !== 1'b0 || if_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b/%b expected 0/0", mem_busy, if_busy); end
        tests++; if (mem_rdy !== 1'b0 || if_rdy !== 1'b0) begin fails++; $display("FAIL reset_rdy: got %b/%b expected 0/0", mem_rdy, if_rdy); end
        tests++; if (mem_ldata !== 32'h0 || if_inst !== 32'h0) begin fails++; $display("FAIL reset_data: got %h/%h expected 0/0", mem_ldata, if_inst); end
        tests++; if (ram_a !== 32'h0 || ram_wr !== 1'b0 || ram_dout !== 8'h0) begin fails++; $display("FAIL reset_ram: got a=%h wr=%b d=%h expected 0", ram_a, ram_wr, ram_dout); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_lw();
        logic [31:0] exp_a;
        load(32'h100, 8'h11); load(32'h101, 8'h22); load(32'h102, 8'h33); load(32'h103, 8'h44);
        mem_addr = 32'h100; mem_width = 3'd4; mem_read_write = 1'b1; mem_needed = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            exp_a = (c <= 4) ? 32'h100 + 32'(c - 1) : 32'h0;
            tests++; if (ram_a !== exp_a || ram_wr !== 1'b0) begin fails++; $display("FAIL lw_ram c%0d: got a=%h wr=%b expected a=%h wr=0", c, ram_a, ram_wr, exp_a); end
            tests++; if (mem_rdy !== (c == 6)) begin fails++; $display("FAIL lw_rdy c%0d: got %b expected %b", c, mem_rdy, (c == 6)); end
            tests++; if (mem_busy !== (c <= 5) || if_busy !== (c <= 5)) begin fails++; $display("FAIL lw_busy c%0d: got %b expected %b", c, mem_busy, (c <= 5)); end
            if (c == 6) begin
                tests++; if (mem_ldata !== 32'h44332211) begin fails++; $display("FAIL lw_data: got %h expected 44332211", mem_ldata); end
            end
            mem_needed = 1'b0;
        end
    endtask

    task automatic test_store();
        logic [31:0] exp_a;
        logic [7:0]  exp_d;
        load(32'h202, 8'h77); load(32'h304, 8'h99);
        mem_addr = 32'h200; mem_width = 3'd2; mem_read_write = 1'b0; mem_sdata = 32'hDEADBEEF; mem_needed = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            exp_a = (c == 1) ? 32'h200 : (c == 2) ? 32'h201 : 32'h0;
            exp_d = (c == 1) ? 8'hEF : (c == 2) ? 8'hBE : 8'h00;
            tests++; if (ram_wr !== (c <= 2) || ram_a !== exp_a || ram_dout !== exp_d) begin fails++; $display("FAIL sh_port c%0d: got wr=%b a=%h d=%h expected wr=%b a=%h d=%h", c, ram_wr, ram_a, ram_dout, (c <= 2), exp_a, exp_d); end
            tests++; if (mem_rdy !== (c == 3)) begin fails++; $display("FAIL sh_rdy c%0d: got %b expected %b", c, mem_rdy, (c == 3)); end
            mem_needed = 1'b0;
        end
        tests++; if (ram_rd(32'h200) !== 8'hEF || ram_rd(32'h201) !== 8'hBE || ram_rd(32'h202) !== 8'h77) begin fails++; $display("FAIL sh_ram: got %h %h %h expected ef be 77", ram_rd(32'h200), ram_rd(32'h201), ram_rd(32'h202)); end

        mem_addr = 32'h300; mem_width = 3'd7; mem_sdata = 32'h12345678; mem_needed = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            tests++; if (ram_wr !== (c <= 4)) begin fails++; $display("FAIL sw7_wr c%0d: got %b expected %b", c, ram_wr, (c <= 4)); end
            tests++; if (mem_rdy !== (c == 5)) begin fails++; $display("FAIL sw7_rdy c%0d: got %b expected %b", c, mem_rdy, (c == 5)); end
            mem_needed = 1'b0;
        end
        tests++; if ({ram_rd(32'h303), ram_rd(32'h302), ram_rd(32'h301), ram_rd(32'h300)} !== 32'h12345678 || ram_rd(32'h304) !== 8'h99) begin fails++; $display("FAIL sw7_ram: got %h%h%h%h next %h expected 12345678 next 99", ram_rd(32'h303), ram_rd(32'h302), ram_rd(32'h301), ram_rd(32'h300), ram_rd(32'h304)); end
    endtask

    task automatic test_priority();
        load(32'h80, 8'hF0);
        load(32'h0, 8'h13); load(32'h1, 8'h05); load(32'h2, 8'h10); load(32'h3, 8'h00);
        mem_addr = 32'h80; mem_width = 3'd1; mem_read_write = 1'b1; mem_needed = 1'b1;
        if_addr = 32'h0; if_needed = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 1) begin
                tests++; if (ram_a !== 32'h80) begin fails++; $display("FAIL prio_first: got a=%h expected 00000080", ram_a); end
                mem_needed = 1'b0;
            end
            if (c == 3) begin
                tests++; if (mem_ldata !== 32'h000000F0) begin fails++; $display("FAIL prio_lb: got %h expected 000000f0", mem_ldata); end
            end
            if (c == 4) begin
                tests++; if (ram_a !== 32'h0 || if_busy !== 1'b1) begin fails++; $display("FAIL prio_if_start: got a=%h busy=%b expected 0/1", ram_a, if_busy); end
                if_needed = 1'b0;
            end
            if (c == 9) begin
                tests++; if (if_inst !== 32'h00100513) begin fails++; $display("FAIL prio_inst: got %h expected 00100513", if_inst); end
            end
            tests++; if (mem_rdy !== (c == 3) || if_rdy !== (c == 9)) begin fails++; $display("FAIL prio_rdy c%0d: got mem=%b if=%b expected %b/%b", c, mem_rdy, if_rdy, (c == 3), (c == 9)); end
        end
    endtask

    task automatic test_flush();
        if_addr = 32'h100; if_needed = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 1) if_needed = 1'b0;
            if (c == 3) begin
                tests++; if (ram_a !== 32'h102 || if_busy !== 1'b1) begin fails++; $display("FAIL flush_pre: got a=%h busy=%b expected 102/1", ram_a, if_busy); end
                if_flush = 1'b1;
            end
            if (c == 4) begin
                tests++; if (if_busy !== 1'b0) begin fails++; $display("FAIL flush_idle: got busy=%b expected 0", if_busy); end
                if_flush = 1'b0;
                mem_addr = 32'h101; mem_width = 3'd1; mem_read_write = 1'b1; mem_needed = 1'b1;
            end
            if (c == 5) begin
                tests++; if (ram_a !== 32'h101 || mem_busy !== 1'b1) begin fails++; $display("FAIL flush_mem_accept: got a=%h busy=%b expected 101/1", ram_a, mem_busy); end
                mem_needed = 1'b0;
            end
            if (c == 7) begin
                tests++; if (mem_ldata !== 32'h00000022) begin fails++; $display("FAIL flush_mem_data: got %h expected 00000022", mem_ldata); end
            end
            tests++; if (if_rdy !== 1'b0 || if_inst !== 32'h00100513) begin fails++; $display("FAIL flush_if c%0d: got rdy=%b inst=%h expected 0/00100513", c, if_rdy, if_inst); end
            tests++; if (mem_rdy !== (c == 7)) begin fails++; $display("FAIL flush_mem_rdy c%0d: got %b expected %b", c, mem_rdy, (c == 7)); end
        end
    endtask

    task automatic test_reset_mid();
        mem_addr = 32'h400; mem_width = 3'd4; mem_read_write = 1'b0; mem_sdata = 32'hCAFEF00D; mem_needed = 1'b1;
        step();
        mem_needed = 1'b0;
        step();
        tests++; if (ram_wr !== 1'b1 || ram_a !== 32'h401) begin fails++; $display("FAIL rstmid_pre: got wr=%b a=%h expected 1/401", ram_wr, ram_a); end
        rst = 1'b1;
        #1;
        tests++; if (ram_wr !== 1'b0 || ram_a !== 32'h0 || ram_dout !== 8'h0) begin fails++; $display("FAIL rstmid_ram: got wr=%b a=%h d=%h expected 0", ram_wr, ram_a, ram_dout); end
        tests++; if (mem_busy !== 1'b0 || mem_ldata !== 32'h0 || if_inst !== 32'h0 || mem_rdy !== 1'b0) begin fails++; $display("FAIL rstmid_out: got busy=%b ld=%h inst=%h rdy=%b expected all 0", mem_busy, mem_ldata, if_inst, mem_rdy); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            tests++; if (mem_rdy !== 1'b0 || mem_busy !== 1'b0) begin fails++; $display("FAIL rstmid_quiet c%0d: got rdy=%b busy=%b expected 0/0", c, mem_rdy, mem_busy); end
        end
        tests++; if (ram_rd(32'h400) !== 8'h0D || ram_rd(32'h401) !== 8'h00) begin fails++; $display("FAIL rstmid_ramdata: got %h %h expected 0d 00", ram_rd(32'h400), ram_rd(32'h401)); end
        mem_addr = 32'h80; mem_width = 3'd1; mem_read_write = 1'b1; mem_needed = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            mem_needed = 1'b0;
            tests++; if (mem_rdy !== (c == 3)) begin fails++; $display("FAIL rstmid_after_rdy c%0d: got %b expected %b", c, mem_rdy, (c == 3)); end
            if (c == 3) begin
                tests++; if (mem_ldata !== 32'h000000F0) begin fails++; $display("FAIL rstmid_after_data: got %h expected 000000f0", mem_ldata); end
            end
        end
    endtask

    task automatic test_wrap();
        load(32'hFFFFFFFF, 8'hAB);
        mem_addr = 32'hFFFFFFFF; mem_width = 3'd2; mem_read_write = 1'b1; mem_needed = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            mem_needed = 1'b0;
            if (c == 1) begin
                tests++; if (ram_a !== 32'hFFFFFFFF) begin fails++; $display("FAIL wrap_a1: got %h expected ffffffff", ram_a); end
            end
            if (c == 2) begin
                tests++; if (ram_a !== 32'h0) begin fails++; $display("FAIL wrap_a2: got %h expected 00000000", ram_a); end
            end
            if (c == 4) begin
                tests++; if (mem_ldata !== 32'h000013AB) begin fails++; $display("FAIL wrap_data: got %h expected 000013ab", mem_ldata); end
            end
            tests++; if (mem_rdy !== (c == 4)) begin fails++; $display("FAIL wrap_rdy c%0d: got %b expected %b", c, mem_rdy, (c == 4)); end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_store();
        test_priority();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Memory controller sitting directly downstream of the MEM stage and beside IF. Arbitrates load/store requests from MEM and instruction fetches from IF onto a single byte-wide synchronous RAM port, serialising 1/2/4-byte accesses. Returns assembled little-endian data with a one-cycle ready pulse and exposes a busy flag so requesters only raise new requests when the controller is idle.

Parameters:
ADDR_LEN, 32, byte address width on all ports.
DATA_LEN, 32, width of load/store/instruction data words.

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-high reset
mem_needed  in  1  MEM request valid (level)
mem_addr  in  ADDR_LEN  MEM byte address
mem_width  in  3  bytes to access: 1, 2 or 4
mem_read_write  in  1  1 = load, 0 = store
mem_sdata  in  DATA_LEN  store data; low mem_width bytes used
mem_rdy  out  1  one-cycle pulse, MEM transaction complete
mem_busy  out  1  controller not idle
mem_ldata  out  DATA_LEN  load result, zero-extended
if_needed  in  1  fetch request valid (level)
if_addr  in  ADDR_LEN  fetch address, always 4 bytes
if_flush  in  1  abort an in-flight or pending fetch (branch taken)
if_rdy  out  1  one-cycle pulse, fetch complete
if_busy  out  1  controller not idle
if_inst  out  DATA_LEN  fetched instruction word
ram_a  out  ADDR_LEN  RAM byte address
ram_wr  out  1  1 = write this cycle
ram_dout  out  8  RAM write byte
ram_din  in  8  RAM read byte, valid the cycle after ram_a presented

Behaviour:
- Reset (async, rst=1): state IDLE, counters 0, mem_rdy=if_rdy=0, mem_ldata=if_inst=0. ram_a/ram_wr/ram_dout are decoded from state and read 0 in IDLE, so ram_wr falls immediately on reset assertion. Partial transactions are discarded; no rdy follows reset release.
- mem_busy = if_busy = (state != IDLE). Both combinational from state.
- States: IDLE, RD, WR. Latched per transaction: owner (MEM/IF), addr, width w, sdata, byte counter cnt (3 bits), assembly buffer.
- IDLE, rising edge: if mem_needed=1, accept MEM (priority over IF) -> RD if mem_read_write=1, else WR. Otherwise, if if_needed=1 and if_flush=0, accept IF -> RD with w=4. cnt<=0, buffer<=0.
- Width decode: mem_width 1 -> 1, 2 -> 2, any other value -> 4.
- RD, cycle with cnt: if cnt<w, ram_a=addr+cnt and ram_wr=0. If cnt>=1, ram_din is captured into buffer byte cnt-1 at the edge. When cnt==w, the edge captures the last byte, writes the assembled word (upper unused bytes 0) to mem_ldata or if_inst, pulses the owner's rdy next cycle, and returns to IDLE. Otherwise cnt<=cnt+1.
- WR, cycle with cnt: ram_wr=1, ram_a=addr+cnt, ram_dout=sdata[8*cnt+7:8*cnt]. At the edge with cnt==w-1, go to IDLE and pulse mem_rdy. Bytes above w are never written.
- Latency, with request seen in cycle 0 while IDLE: read rdy in cycle w+2 (LW 6, LB 3); write rdy in cycle w+1 (SW 5).
- rdy is high exactly one cycle, and state is already IDLE in that cycle. A new request seen in the rdy cycle is accepted at its end edge.
- mem_ldata and if_inst hold until overwritten by the next completed read of the same owner.
- if_flush=1 while owner=IF in RD: at the next edge go to IDLE with no if_rdy and if_inst unchanged. if_flush does not affect MEM transactions.
- Address arithmetic is modulo 2^ADDR_LEN (wraps at 0xFFFFFFFF).

Test Plan:
1. LW at 0x100, RAM[0x100..0x103]=11,22,33,44 -> ram_a 0x100..0x103 in cycles 1-4, mem_rdy high only in cycle 6, mem_ldata=0x44332211, busy 1 in cycles 1-5.
2. SH at 0x200, sdata=0xDEADBEEF, width 2 -> ram_wr=1 in cycle 1 (0x200<-EF) and cycle 2 (0x201<-BE), mem_rdy in cycle 3, RAM[0x202] unchanged; width=7 at 0x300 writes 4 bytes.
3. if_needed (0x0) and mem_needed LB (0x80, byte 0xF0) asserted together in cycle 0 -> MEM first: mem_ldata=0x000000F0, mem_rdy in cycle 3. IF accepted at end of cycle 3, if_rdy in cycle 9, if_inst = RAM[0..3].
4. IF fetch running, if_flush=1 in cycle 3 -> IDLE in cycle 4, no if_rdy, if_inst unchanged. A mem_needed raised in cycle 4 is accepted at the end of cycle 4.
5. rst pulsed between edges during cycle 2 of an SW -> ram_wr drops to 0 at once, all outputs 0. After release no mem_rdy appears and the next request starts cleanly.
6. LH at 0xFFFFFFFF -> ram_a 0xFFFFFFFF then 0x00000000, mem_ldata upper 16 bits 0.
